// File: rtl/pci_pkg.sv
// Shared PCI arbiter definitions: FSM states, slot count and address decode.
// Also reused by device models that need the same decode rules.
package pci_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    TURN  = 3'd4
  } state_t;

  localparam int NSLOT = 3;
  localparam int DEC_LO = 4;
  localparam int DEC_HI = 5;
  localparam logic [1:0] NO_TARGET = 2'b11;

  // A master never selects itself as target.
  function automatic logic [NSLOT-1:0] slot_decode(
    input logic [1:0] field,
    input logic [1:0] own
  );
    logic [NSLOT-1:0] oh;
    oh = '0;
    unique case (1'b1)
      (field == NO_TARGET) || (field == own): oh = '0;
      default: oh = {{(NSLOT-1){1'b0}}, 1'b1} << field;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// Round-robin winner search over the request vector.
// The search starts one slot past the last owner and wraps.
module rr_pick
  import pci_pkg::*;
(
  input  logic [NSLOT-1:0] req,
  input  logic [1:0]       last,
  output logic             valid,
  output logic [1:0]       idx
);

  logic [2:0] start;
  logic [2:0] c;

  always_comb begin
    start = (last >= 2'(NSLOT - 1)) ? 3'd0 : {1'b0, last} + 3'd1;
    valid = 1'b0;
    idx = '0;
    c = '0;
    for (int k = 0; k < NSLOT; k++) begin
      c = start + 3'(k);
      if (c >= 3'(NSLOT)) c = c - 3'(NSLOT);
      if (!valid && req[c[1:0]]) begin
        valid = 1'b1;
        idx = c[1:0];
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Three-slot PCI bus arbiter with target decode and master-abort detection.
// Shared bus lines are pulled up, so anything other than a driven 0 reads high.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int GNT_TIMEOUT = 16,
  parameter int DEVSEL_WINDOW = 4
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [2:0]  req_n,
  output logic [2:0]  gnt_n,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic        seldev_n,
  input  logic [31:0] addr_data,
  output logic [2:0]  sel_slot,
  output logic [1:0]  owner,
  output logic        bus_busy,
  output logic        master_abort
);

  localparam int GW = $clog2(GNT_TIMEOUT + 1);

  state_t         state, state_nx;
  logic [1:0]     owner_q, owner_nx;
  logic [GW-1:0]  gcnt, gcnt_nx;
  logic [2:0]     dcnt, dcnt_nx;
  logic           claimed, claimed_nx;
  logic [2:0]     sel_q, sel_nx;
  logic           abort_q, abort_nx;

  logic frame_hi, irdy_hi, seldev_hi;
  logic pick_valid;
  logic [1:0] pick_idx;
  logic addr_unused;

  assign frame_hi  = (frame_n !== 1'b0);
  assign irdy_hi   = (irdy_n !== 1'b0);
  assign seldev_hi = (seldev_n !== 1'b0);
  assign addr_unused = ^{addr_data[31:DEC_HI+1], addr_data[DEC_LO-1:0]};

  rr_pick u_pick (
    .req   (~req_n),
    .last  (owner_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nx = state;
    owner_nx = owner_q;
    gcnt_nx = gcnt;
    dcnt_nx = dcnt;
    claimed_nx = claimed;
    sel_nx = '0;
    abort_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid && frame_hi && irdy_hi) begin
          state_nx = GRANT;
          owner_nx = pick_idx;
          gcnt_nx = '0;
        end
      end
      GRANT: begin
        if (!frame_hi) begin
          state_nx = ADDR;
          sel_nx = slot_decode(addr_data[DEC_HI:DEC_LO], owner_q);
          dcnt_nx = '0;
          claimed_nx = 1'b0;
        end else if (gcnt == GW'(GNT_TIMEOUT - 1)) begin
          state_nx = IDLE;
        end else begin
          gcnt_nx = gcnt + 1'b1;
        end
      end
      ADDR: begin
        state_nx = DATA;
        dcnt_nx = 3'd1;
        if (!seldev_hi) claimed_nx = 1'b1;
      end
      DATA: begin
        if (dcnt != 3'd7) dcnt_nx = dcnt + 3'd1;
        if (!seldev_hi) claimed_nx = 1'b1;
        if (dcnt == 3'(DEVSEL_WINDOW - 1) && !claimed && seldev_hi)
          abort_nx = 1'b1;
        if (frame_hi && irdy_hi) state_nx = TURN;
      end
      TURN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state <= IDLE;
      owner_q <= 2'(NSLOT - 1);
      gcnt <= '0;
      dcnt <= '0;
      claimed <= 1'b0;
      sel_q <= '0;
      abort_q <= 1'b0;
    end else begin
      state <= state_nx;
      owner_q <= owner_nx;
      gcnt <= gcnt_nx;
      dcnt <= dcnt_nx;
      claimed <= claimed_nx;
      sel_q <= sel_nx;
      abort_q <= abort_nx;
    end
  end

  assign gnt_n = (state == GRANT) ? ~(3'b001 << owner_q) : 3'b111;
  assign sel_slot = sel_q;
  assign owner = owner_q;
  assign bus_busy = (state != IDLE);
  assign master_abort = abort_q;

endmodule

// File: doc/pci_arbiter.md
PCI_ARBITER -- requirements
Module: pci_arbiter

Interface
REQ-001 SHALL have port clk  input  1  bus clock, all logic on rising edge.
REQ-002 SHALL have port areset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port req_n  input  3  per-slot bus request, active-low, bit i = slot i.
REQ-004 SHALL have port gnt_n  output  3  per-slot bus grant, active-low, at most one bit low.
REQ-005 SHALL have port frame_n  input  1  shared FRAME, active-low; z is treated as 1 (pulled up).
REQ-006 SHALL have port irdy_n  input  1  shared IRDY, active-low; z treated as 1.
REQ-007 SHALL have port seldev_n  input  1  shared target-claim (DEVSEL), active-low; z treated as 1.
REQ-008 SHALL have port addr_data  input  32  shared address/data bus, sampled only in the address phase.
REQ-009 SHALL have port sel_slot  output  3  one-hot target select to the addressed slot.
REQ-010 SHALL have port owner  output  2  index of the current or last granted slot.
REQ-011 SHALL have port bus_busy  output  1  high from grant until the turnaround completes.
REQ-012 SHALL have port master_abort  output  1  one-cycle pulse when no target claims the transaction.
REQ-013 SHALL have parameter GNT_TIMEOUT, default 16, cycles allowed from grant to FRAME assertion.
REQ-014 SHALL have parameter DEVSEL_WINDOW, default 4, cycles allowed from address phase to seldev_n low.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT, ADDR, DATA, TURN.
REQ-016 IDLE: when any req_n bit is low and frame_n=1 and irdy_n=1, SHALL pick the winner and drive its gnt_n bit low on the next edge; go to GRANT.
REQ-017 Arbitration SHALL be round-robin: search starts at owner+1 mod 3, wraps 2->0; slot index 3 is never granted.
REQ-018 GRANT: on the first edge frame_n=0, SHALL capture addr_data and go to ADDR; gnt_n returns to 111 on the same edge.
REQ-019 GRANT: if the winner releases req_n before FRAME, the grant SHALL be held until the timeout.
REQ-020 GRANT: if frame_n stays 1 for GNT_TIMEOUT edges, SHALL set gnt_n=111, advance owner past the winner, pulse nothing, and return to IDLE.
REQ-021 ADDR: decode SHALL be addr[5:4]: 00->slot0, 01->slot1, 10->slot2, 11->no target; sel_slot is driven for exactly one cycle.
REQ-022 Decode to the owner's own slot, or to 11, SHALL produce sel_slot=000.
REQ-023 ADDR SHALL last one cycle, then DATA.
REQ-024 DATA: a 3-bit counter SHALL count edges since ADDR; if seldev_n was never low after DEVSEL_WINDOW edges, SHALL pulse master_abort once.
REQ-025 DATA SHALL exit to TURN on the first edge with frame_n=1 and irdy_n=1, including after a master abort.
REQ-026 TURN SHALL last exactly one cycle with bus_busy=1 and gnt_n=111, then IDLE with bus_busy=0.
REQ-027 bus_busy SHALL be 1 in GRANT, ADDR, DATA, TURN and 0 in IDLE.
REQ-028 A new grant SHALL never be issued while frame_n=0 or irdy_n=0, even in IDLE.
REQ-029 Minimum back-to-back spacing: the last data edge, then TURN, then IDLE, then a new grant (3 edges).

Reset
REQ-030 On an edge with areset=1, SHALL set state=IDLE, gnt_n=111, sel_slot=000, owner=2 (so slot 0 has first priority), bus_busy=0, master_abort=0, counters=0.
REQ-031 Reset asserted mid-transaction SHALL take effect on that edge regardless of bus state; areset takes priority over all transitions.

Structure
REQ-032 FSM state encoding, slot count 3, decode field position [5:4] and the no-target code SHALL live in a shared package pci_pkg, reused by the device models.
REQ-033 The round-robin winner search SHALL be a sub-module rr_pick (inputs: request vector, last owner; outputs: valid, index), purely combinational; all other logic stays in pci_arbiter.

Verification
REQ-034 Reset, then req_n=110 -> gnt_n=110 on the next edge, owner=0, bus_busy=1.
REQ-035 owner=0, req_n=000 held through a completed transaction -> next grant goes to slot 1, then slot 2, then slot 0.
REQ-036 Slot 0 granted, frame_n low with addr_data=0x10 -> sel_slot=010 for one cycle; seldev_n low at +2 -> no master_abort; frame_n and irdy_n high -> TURN, then IDLE.
REQ-037 Address 0x30 (no target) -> sel_slot=000 and master_abort pulses 4 edges after ADDR.
REQ-038 Grant to slot 2 with frame_n held high for 16 edges -> gnt_n=111, state IDLE, owner=2, next request served from slot 0.
REQ-039 areset pulsed during DATA with frame_n=0 -> all outputs at reset values on that edge; no grant until frame_n=1 and irdy_n=1.
